// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared types, shape table and LFSR taps for the playfield engine
package tetris_pkg;

  typedef enum logic [2:0] {
    PIECE_I = 3'd0,
    PIECE_J = 3'd1,
    PIECE_L = 3'd2,
    PIECE_O = 3'd3,
    PIECE_S = 3'd4,
    PIECE_T = 3'd5,
    PIECE_Z = 3'd6
  } piece_t;

  typedef enum logic [2:0] {
    CMD_LEFT      = 3'd0,
    CMD_RIGHT     = 3'd1,
    CMD_ROT_CW    = 3'd2,
    CMD_SOFT_DOWN = 3'd3,
    CMD_HARD_DROP = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    ST_SPAWN     = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DROP      = 3'd2,
    ST_LOCK      = 3'd3,
    ST_CLEAR     = 3'd4,
    ST_GAME_OVER = 3'd5
  } state_t;

  // Fibonacci taps 16,14,13,11 expressed as a mask over lfsr[15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // [type][rot] -> four row nibbles, element 0 is the top row, bit 3 is box column 0.
  // Each rotation is a 90-degree clockwise step from the previous one.
  localparam logic [0:3][3:0] SHAPES [7][4] = '{
    '{16'h0F00, 16'h2222, 16'h00F0, 16'h4444},  // I
    '{16'h8E00, 16'h6440, 16'h0E20, 16'h44C0},  // J
    '{16'h2E00, 16'h4460, 16'h0E80, 16'hC440},  // L
    '{16'h6600, 16'h6600, 16'h6600, 16'h6600},  // O
    '{16'h6C00, 16'h4620, 16'h06C0, 16'h8C40},  // S
    '{16'h4E00, 16'h4640, 16'h0E40, 16'h4C40},  // T
    '{16'hC600, 16'h2640, 16'h0C60, 16'h4C80}   // Z
  };

endpackage

// File: rtl/tetris_field_engine_rom.sv
// rtl/tetris_field_engine_rom.sv - combinational (type, rot) to shape row lookup
module piece_shape_rom
  import tetris_pkg::*;
(
  input  logic [2:0]      shape_type,
  input  logic [1:0]      shape_rot,
  output logic [0:3][3:0] shape_rows
);

  // Table lookup; code 7 is not a piece and yields an empty shape
  always_comb begin
    shape_rows = '0;
    if (shape_type != 3'd7) shape_rows = SHAPES[shape_type][shape_rot];
  end

endmodule

// File: rtl/tetris_field_engine.sv
// rtl/tetris_field_engine.sv - playfield engine: active piece, gravity, locking, line clear
module tetris_field_engine
  import tetris_pkg::*;
#(
  parameter int          COLS           = 10,
  parameter int          ROWS           = 20,
  parameter int          GRAVITY_FRAMES = 30,
  parameter logic [15:0] SEED           = 16'hACE1
) (
  input  logic                           frame_clk,
  input  logic                           Reset,
  input  logic                           cmd_valid,
  input  logic [2:0]                     cmd,
  output logic                           cmd_ready,
  input  logic                           force_en,
  input  logic [2:0]                     force_type,
  output logic [ROWS-1:0][COLS-1:0]      field_out,
  output logic [2:0]                     piece_type,
  output logic [1:0]                     piece_rot,
  output logic signed [$clog2(COLS)+1:0] piece_x,
  output logic [$clog2(ROWS):0]          piece_y,
  output logic [15:0]                    lines_cleared,
  output logic                           game_over
);

  localparam int XW = $clog2(COLS) + 2;
  localparam int YW = $clog2(ROWS) + 1;
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int GW = $clog2(GRAVITY_FRAMES);
  localparam logic signed [XW-1:0] SPAWN_X = XW'(COLS / 2 - 2);

  state_t                    state;
  logic [ROWS-1:0][COLS-1:0] field;
  logic [2:0]                ptype;
  logic [1:0]                prot;
  logic signed [XW-1:0]      px;
  logic [YW-1:0]             py;
  logic [GW-1:0]             grav_cnt;
  logic                      grav_pending;
  logic [RW-1:0]             clr_idx;
  logic [15:0]               lfsr;

  logic [2:0]                spawn_type;
  logic [2:0]                cand_type;
  logic [1:0]                cand_rot;
  logic signed [XW-1:0]      cand_x;
  logic [YW-1:0]             cand_y;
  logic [0:3][3:0]           cur_rows;
  logic [0:3][3:0]           cand_rows;
  logic [ROWS-1:0][COLS-1:0] cur_mask;
  logic                      cand_collide;
  logic                      grav_tick;

  // Field cells covered by a pose; cells falling outside the field are dropped
  function automatic logic [ROWS-1:0][COLS-1:0] pose_mask(
    input logic [0:3][3:0]      shp,
    input logic signed [XW-1:0] x,
    input logic [YW-1:0]        y
  );
    logic [ROWS-1:0][COLS-1:0] m;
    int row, col, bitpos;
    m = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        row    = int'(y) + r;
        col    = int'(x) + c;
        bitpos = COLS - 1 - col;
        if (shp[r][3-c] && col >= 0 && col < COLS && row < ROWS)
          m[row[RW-1:0]][bitpos[CW-1:0]] = 1'b1;
      end
    end
    return m;
  endfunction

  // True when any set cell of a pose lies left, right or below the field
  function automatic logic pose_oob(
    input logic [0:3][3:0]      shp,
    input logic signed [XW-1:0] x,
    input logic [YW-1:0]        y
  );
    logic oob;
    int row, col;
    oob = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        row = int'(y) + r;
        col = int'(x) + c;
        if (shp[r][3-c] && (col < 0 || col >= COLS || row >= ROWS)) oob = 1'b1;
      end
    end
    return oob;
  endfunction

  piece_shape_rom u_rom_cur (
    .shape_type (ptype),
    .shape_rot  (prot),
    .shape_rows (cur_rows)
  );

  piece_shape_rom u_rom_cand (
    .shape_type (cand_type),
    .shape_rot  (cand_rot),
    .shape_rows (cand_rows)
  );

  assign cmd_ready  = (state == ST_PLAY);
  assign grav_tick  = (state == ST_PLAY) && (grav_cnt == GW'(GRAVITY_FRAMES - 1));
  assign spawn_type = force_en ? force_type : lfsr[2:0];

  // Candidate pose: spawn pose, the commanded move, a gravity step, or the next drop row
  always_comb begin
    cand_type = ptype;
    cand_rot  = prot;
    cand_x    = px;
    cand_y    = py;
    case (state)
      ST_SPAWN: begin
        cand_type = spawn_type;
        cand_rot  = 2'd0;
        cand_x    = SPAWN_X;
        cand_y    = '0;
      end
      ST_PLAY: begin
        if (cmd_valid) begin
          case (cmd)
            CMD_LEFT:      cand_x   = px - XW'(1);
            CMD_RIGHT:     cand_x   = px + XW'(1);
            CMD_ROT_CW:    cand_rot = prot + 2'd1;
            CMD_SOFT_DOWN: cand_y   = py + YW'(1);
            default:       ;
          endcase
        end else if (grav_tick || grav_pending) begin
          cand_y = py + YW'(1);
        end
      end
      ST_DROP: cand_y = py + YW'(1);
      default: ;
    endcase
  end

  // Collision test for the candidate and the composited view of the current pose
  always_comb begin
    cand_collide = pose_oob(cand_rows, cand_x, cand_y) ||
                   (|(pose_mask(cand_rows, cand_x, cand_y) & field));
    cur_mask     = pose_mask(cur_rows, px, py);
    field_out    = field;
    if (state == ST_PLAY || state == ST_DROP) field_out = field | cur_mask;
  end

  assign piece_type = ptype;
  assign piece_rot  = prot;
  assign piece_x    = px;
  assign piece_y    = py;

  // Main FSM: spawn, play with gravity, drop, lock, row-by-row clear, game over
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state         <= ST_SPAWN;
      field         <= '0;
      ptype         <= '0;
      prot          <= '0;
      px            <= '0;
      py            <= '0;
      grav_cnt      <= '0;
      grav_pending  <= 1'b0;
      clr_idx       <= '0;
      lfsr          <= SEED;
      lines_cleared <= '0;
      game_over     <= 1'b0;
    end else begin
      lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
      case (state)
        ST_SPAWN: begin
          if (spawn_type != 3'd7) begin
            ptype        <= spawn_type;
            prot         <= 2'd0;
            px           <= SPAWN_X;
            py           <= '0;
            grav_cnt     <= '0;
            grav_pending <= 1'b0;
            if (cand_collide) begin
              state     <= ST_GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state <= ST_PLAY;
            end
          end
        end
        ST_PLAY: begin
          grav_cnt <= grav_tick ? '0 : grav_cnt + GW'(1);
          if (cmd_valid) begin
            // a command wins over a coincident tick; the tick is replayed next cycle
            if (grav_tick) grav_pending <= 1'b1;
            if (cmd == CMD_HARD_DROP) begin
              state <= ST_DROP;
            end else if (!cand_collide) begin
              px   <= cand_x;
              py   <= cand_y;
              prot <= cand_rot;
            end else if (cmd == CMD_SOFT_DOWN) begin
              state <= ST_LOCK;
            end
          end else if (grav_tick || grav_pending) begin
            grav_pending <= 1'b0;
            if (!cand_collide) py <= cand_y;
            else               state <= ST_LOCK;
          end
        end
        ST_DROP: begin
          if (!cand_collide) py <= cand_y;
          else               state <= ST_LOCK;
        end
        ST_LOCK: begin
          field   <= field | cur_mask;
          clr_idx <= RW'(ROWS - 1);
          state   <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (&field[clr_idx]) begin
            // collapse everything above the full row; the same index is rescanned
            for (int r = ROWS - 1; r > 0; r--) begin
              if (r <= int'(clr_idx)) field[r] <= field[r-1];
            end
            field[0] <= '0;
            if (lines_cleared != 16'hFFFF) lines_cleared <= lines_cleared + 16'd1;
          end else if (clr_idx == '0) begin
            state <= ST_SPAWN;
          end else begin
            clr_idx <= clr_idx - RW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
